// File: rtl/sram_layer_set_loader.sv
// -----------------------------------------------------------------------------
// sram_layer_set_loader
//
// Banked weight SRAM for one layer: SET_NUM single-port macros, one per neuron
// set, behind a small controller with two ways in:
//   * a streaming load engine that fills every set in set-major order
//     (set 0 addr 0..DEPTH-1, then set 1, ...) with auto-incrementing addresses;
//   * a broadcast read port that sends one address to all sets, gated by a
//     per-set mask, and returns every set's word side by side.
//
// Handshake rule (load and read ports alike): a transfer happens on a rising
// clk edge where the producer's valid and this block's ready are both high.
// Ready never depends on valid. load_ready_o is high only in LOAD and
// rd_ready_o is high only in IDLE, so loads and reads never share a macro cycle.
//
// Optional build macro RD_OUT_REG_EN: adds an output register on rd_data_o /
// rd_data_valid_o (read latency 2 instead of 1, still one read per cycle) and
// delays load_done_o by one more cycle so it trails any in-flight read.
//
// Ports
//   clk, reset_n     clock, asynchronous active-low reset
//   load_start_i     pulse in IDLE: begin a full-array fill
//   load_valid_i     load word valid
//   load_data_i      load word
//   load_ready_o     high in LOAD
//   load_done_o      one-cycle pulse after the last word is written
//   rd_valid_i       read request
//   rd_ready_o       high in IDLE
//   rd_address_i     address broadcast to all sets
//   rd_set_mask_i    per-set read enable
//   rd_data_o        set k at [k*BIT_WIDTH_SRAM +: BIT_WIDTH_SRAM], 0 when idle
//   rd_data_valid_o  rd_data_o valid
//   busy_o           high in LOAD
//   state_o          debug view of the FSM state (0 = IDLE, 1 = LOAD)
// -----------------------------------------------------------------------------
module sram_layer_set_loader #(
  parameter int BIT_WIDTH_SRAM    = 160,
  parameter int DEPTH_SRAM        = 980,
  parameter int BIT_WIDTH_ADDRESS = 10,
  parameter int SET_NUM           = 10,
  parameter int BIT_WIDTH_SET     = 4
) (
  input  logic                                clk,
  input  logic                                reset_n,
  input  logic                                load_start_i,
  input  logic                                load_valid_i,
  input  logic [BIT_WIDTH_SRAM-1:0]           load_data_i,
  output logic                                load_ready_o,
  output logic                                load_done_o,
  input  logic                                rd_valid_i,
  output logic                                rd_ready_o,
  input  logic [BIT_WIDTH_ADDRESS-1:0]        rd_address_i,
  input  logic [SET_NUM-1:0]                  rd_set_mask_i,
  output logic [BIT_WIDTH_SRAM*SET_NUM-1:0]   rd_data_o,
  output logic                                rd_data_valid_o,
  output logic                                busy_o,
  output logic                                state_o
);

  localparam logic [BIT_WIDTH_ADDRESS-1:0] ADDR_LAST = BIT_WIDTH_ADDRESS'(DEPTH_SRAM - 1);
  localparam logic [BIT_WIDTH_SET-1:0]     SET_LAST  = BIT_WIDTH_SET'(SET_NUM - 1);
  // Index width the memory array actually needs; addresses reaching a macro
  // are always < DEPTH_SRAM, so the upper address bits are zero there.
  localparam int MEM_AW = (DEPTH_SRAM > 1) ? $clog2(DEPTH_SRAM) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_LOAD = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [BIT_WIDTH_ADDRESS-1:0] load_addr;
  logic [BIT_WIDTH_SET-1:0]     load_set;
  logic                         load_beat;
  logic                         last_beat;
  logic                         load_go;
  logic                         rd_accept;
  logic                         rd_in_range;
  logic [SET_NUM-1:0]           rd_mask_q;
  logic                         rd_valid_q;
  logic                         done_q;
  logic [BIT_WIDTH_SRAM*SET_NUM-1:0] rd_data_raw;

  assign load_beat   = load_valid_i & load_ready_o;
  assign last_beat   = load_beat & (load_set == SET_LAST) & (load_addr == ADDR_LAST);
  assign load_go     = (state == S_IDLE) & load_start_i;
  assign rd_accept   = rd_valid_i & rd_ready_o;
  assign rd_in_range = 32'(rd_address_i) < DEPTH_SRAM;

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (load_start_i) state_nxt = S_LOAD;
      S_LOAD: if (last_beat)    state_nxt = S_IDLE;
      default:                  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    load_ready_o = (state == S_LOAD);
    busy_o       = (state == S_LOAD);
    rd_ready_o   = (state == S_IDLE);
    state_o      = state;
  end

  // ---------------------------------------------------------------------------
  // Load address generator: addr runs fastest, set advances on addr wrap.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      load_addr <= '0;
      load_set  <= '0;
    end else if (load_go) begin
      load_addr <= '0;
      load_set  <= '0;
    end else if (load_beat) begin
      if (load_addr == ADDR_LAST) begin
        load_addr <= '0;
        load_set  <= load_set + BIT_WIDTH_SET'(1);
      end else begin
        load_addr <= load_addr + BIT_WIDTH_ADDRESS'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read pipeline: the registered mask selects which macro outputs are shown.
  // An out-of-range address clears the mask, so such a read returns zeros
  // without touching any macro.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_mask_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      rd_mask_q  <= rd_accept ? (rd_set_mask_i & {SET_NUM{rd_in_range}}) : '0;
      rd_valid_q <= rd_accept;
      done_q     <= last_beat;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-set macros. Idle macros keep CEB high with address and data at zero
  // so the buses do not toggle.
  // ---------------------------------------------------------------------------
  for (genvar k = 0; k < SET_NUM; k++) begin : g_set
    logic                         wr_sel;
    logic                         rd_sel;
    logic                         ceb;
    logic                         web;
    logic [BIT_WIDTH_ADDRESS-1:0] a;
    logic [BIT_WIDTH_SRAM-1:0]    d;
    logic [BIT_WIDTH_SRAM-1:0]    q;
    logic [BIT_WIDTH_SRAM-1:0]    mem [DEPTH_SRAM];

    always_comb begin
      wr_sel = load_beat & (load_set == BIT_WIDTH_SET'(k));
      rd_sel = rd_accept & rd_set_mask_i[k] & rd_in_range;
      ceb    = ~(wr_sel | rd_sel);
      web    = ~wr_sel;
      a      = wr_sel ? load_addr : (rd_sel ? rd_address_i : '0);
      d      = wr_sel ? load_data_i : '0;
    end

    // Single-port macro model: write or registered read, never both.
    always_ff @(posedge clk) begin
      if (!ceb) begin
        if (!web) mem[a[MEM_AW-1:0]] <= d;
        else      q <= mem[a[MEM_AW-1:0]];
      end
    end

    assign rd_data_raw[k*BIT_WIDTH_SRAM +: BIT_WIDTH_SRAM] = rd_mask_q[k] ? q : '0;
  end

`ifdef RD_OUT_REG_EN
  logic [BIT_WIDTH_SRAM*SET_NUM-1:0] rd_data_r;
  logic                              rd_valid_r;
  logic                              done_r;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data_r  <= '0;
      rd_valid_r <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      rd_data_r  <= rd_data_raw;
      rd_valid_r <= rd_valid_q;
      done_r     <= done_q;
    end
  end

  assign rd_data_o       = rd_data_r;
  assign rd_data_valid_o = rd_valid_r;
  assign load_done_o     = done_r;
`else
  assign rd_data_o       = rd_data_raw;
  assign rd_data_valid_o = rd_valid_q;
  assign load_done_o     = done_q;
`endif

endmodule

// File: tb/tb_sram_layer_set_loader.sv
module tb_sram_layer_set_loader;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int AW = 3;
  localparam int S  = 3;
  localparam int SW = 2;
  localparam int N  = S * D;
`ifdef RD_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           reset_n;
  logic           load_start_i;
  logic           load_valid_i;
  logic [W-1:0]   load_data_i;
  logic           load_ready_o;
  logic           load_done_o;
  logic           rd_valid_i;
  logic           rd_ready_o;
  logic [AW-1:0]  rd_address_i;
  logic [S-1:0]   rd_set_mask_i;
  logic [S*W-1:0] rd_data_o;
  logic           rd_data_valid_o;
  logic           busy_o;
  logic           state_o;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  sram_layer_set_loader #(
    .BIT_WIDTH_SRAM(W), .DEPTH_SRAM(D), .BIT_WIDTH_ADDRESS(AW),
    .SET_NUM(S), .BIT_WIDTH_SET(SW)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .load_start_i(load_start_i), .load_valid_i(load_valid_i),
    .load_data_i(load_data_i), .load_ready_o(load_ready_o),
    .load_done_o(load_done_o), .rd_valid_i(rd_valid_i),
    .rd_ready_o(rd_ready_o), .rd_address_i(rd_address_i),
    .rd_set_mask_i(rd_set_mask_i), .rd_data_o(rd_data_o),
    .rd_data_valid_o(rd_data_valid_o), .busy_o(busy_o), .state_o(state_o)
  );

  // ---------------- reference model + scoreboard ----------------
  logic [W-1:0]   model [S][D];   // memory image as the spec's fill order defines it
  logic [S*W-1:0] exp_q[$];       // expected read data, in issue order
  int             exp_cyc_q[$];   // cycle in which each read must come back
  int             done_q[$];      // cycle in which each load_done_o must pulse
  int             checks = 0;
  int             errors = 0;

  task automatic chk(input string name, input logic [S*W-1:0] act, input logic [S*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [S*W-1:0] exp_read(input int a, input logic [S-1:0] m);
    logic [S*W-1:0] r = '0;
    for (int k = 0; k < S; k++)
      if (m[k] && a < D) r[k*W +: W] = model[k][a];
    return r;
  endfunction

  // Drives a request into the current cycle and records what must come back.
  task automatic put_read(input int a, input logic [S-1:0] m);
    rd_valid_i    = 1'b1;
    rd_address_i  = AW'(a);
    rd_set_mask_i = m;
    chk("rd_ready", rd_ready_o, 1);
    exp_q.push_back(exp_read(a, m));
    exp_cyc_q.push_back(cyc + LAT);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (reset_n) begin
      if (rd_data_valid_o) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected @cyc %0d: got valid data %0h expected no read", cyc, rd_data_o);
        end else begin
          chk("rd_data", rd_data_o, exp_q.pop_front());
          chk("rd_latency", (S*W)'(cyc), (S*W)'(exp_cyc_q.pop_front()));
        end
      end else begin
        chk("rd_data_idle", rd_data_o, '0);
      end
      if (load_done_o) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected @cyc %0d: got load_done_o=1 expected 0", cyc);
        end else begin
          chk("done_cycle", (S*W)'(cyc), (S*W)'(done_q.pop_front()));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    rd_valid_i = 1'b0; load_valid_i = 1'b0; load_start_i = 1'b0;
  endtask

  // mode 0: data 0x100+i, no gaps; mode 1: same data, valid toggles every
  // other cycle; mode 2: random data, random gaps, stray load_start_i pulses.
  // abort_after >= 0 stops after that many beats without finishing.
  task automatic load_all(input int mode, input bit with_rd, input int ra,
                          input logic [S-1:0] rm, input int abort_after);
    logic [W-1:0] v;
    int gaps;
    next_cycle();
    load_start_i = 1'b1;
    if (with_rd) put_read(ra, rm);
    next_cycle();
    load_start_i = 1'b0;
    rd_valid_i   = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (abort_after >= 0 && i == abort_after) return;
      gaps = (mode == 1) ? (i > 0 ? 1 : 0) : (mode == 2 ? $urandom_range(0, 2) : 0);
      for (int g = 0; g < gaps; g++) begin
        load_valid_i = 1'b0;
        chk("ready_in_gap", load_ready_o, 1);
        next_cycle();
      end
      v = (mode == 2) ? W'($urandom) : W'(16'h100 + i);
      load_valid_i = 1'b1;
      load_data_i  = v;
      if (mode == 2) load_start_i = 1'($urandom_range(0, 1));
      chk("load_ready", load_ready_o, 1);
      chk("busy", busy_o, 1);
      if (abort_after < 0) model[i / D][i % D] = v;
      if (i == N - 1) done_q.push_back(cyc + LAT);
      next_cycle();
    end
    load_valid_i = 1'b0;
    load_start_i = 1'b0;
    chk("ready_after_load", load_ready_o, 0);
    chk("rd_ready_after_load", rd_ready_o, 1);
  endtask

  task automatic random_reads(input int n);
    for (int i = 0; i < n; i++) begin
      next_cycle();
      if ($urandom_range(0, 3) == 0) rd_valid_i = 1'b0;
      else put_read($urandom_range(0, (1 << AW) - 1), S'($urandom));
    end
    next_cycle();
    rd_valid_i = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    reset_n = 1'b0;
    idle_inputs();
    load_data_i = '0; rd_address_i = '0; rd_set_mask_i = '0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    chk("reset_rd_ready", rd_ready_o, 1);
    chk("reset_rd_valid", rd_data_valid_o, 0);
    chk("reset_rd_data", rd_data_o, '0);
    chk("reset_load_ready", load_ready_o, 0);
    chk("reset_busy", busy_o, 0);
    chk("reset_done", load_done_o, 0);
    chk("reset_state", state_o, 0);

    // Plain fill, then the directed reads.
    load_all(0, 0, 0, '0, -1);
    next_cycle();
    put_read(2, 3'b111);
    chk("fill_image_const", exp_q[exp_q.size()-1], {16'h10A, 16'h106, 16'h102});
    next_cycle(); put_read(1, 3'b010);
    next_cycle(); put_read(0, 3'b111);
    next_cycle(); put_read(1, 3'b111);
    next_cycle(); put_read(3, 3'b111);
    next_cycle(); put_read(5, 3'b111);   // out of range: zeros with valid
    next_cycle(); put_read(1, 3'b000);   // empty mask: zeros with valid
    next_cycle(); idle_inputs();
    repeat (3) next_cycle();

    // Stalled fill with the same data: image must be unchanged.
    load_all(1, 0, 0, '0, -1);
    for (int a = 0; a < D; a++) begin next_cycle(); put_read(a, 3'b111); end
    next_cycle(); idle_inputs();
    random_reads(30);

    // Random fill with a read accepted in the same cycle as load_start_i.
    load_all(2, 1, 3, 3'b101, -1);
    random_reads(30);
    repeat (3) next_cycle();

    // Reset in the middle of a fill.
    load_all(0, 0, 0, '0, 5);
    load_valid_i = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_state", state_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_rd_ready", rd_ready_o, 1);
    chk("midrst_done", load_done_o, 0);
    next_cycle();
    reset_n = 1'b1;
    repeat (3) next_cycle();
    chk("midrst_no_done_pending", (S*W)'(done_q.size()), '0);

    load_all(2, 0, 0, '0, -1);
    random_reads(30);
    repeat (LAT + 3) next_cycle();

    chk("reads_drained", (S*W)'(exp_q.size()), '0);
    chk("done_drained", (S*W)'(done_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got no end of sequence expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_layer_set_loader.md
Name: sram_layer_set_loader

Overview:
- Parametrised, banked weight-SRAM subsystem for a layer: SET_NUM single-port SRAM macros (one per neuron set) behind one controller.
- Adds a streaming load engine that fills all sets in set-major order with auto-incrementing addresses.
- Adds a broadcast read port with per-set mask and a read-data valid strobe.
- Sits between the host/DMA weight loader and the neuron-set compute array.

Parameters:
BIT_WIDTH_SRAM, 160, word width of each set's SRAM
DEPTH_SRAM, 980, words per set
BIT_WIDTH_ADDRESS, 10, address width; must satisfy 2^BIT_WIDTH_ADDRESS >= DEPTH_SRAM
SET_NUM, 10, number of sets/macros
BIT_WIDTH_SET, 4, set-index width; must satisfy 2^BIT_WIDTH_SET >= SET_NUM

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
load_start_i  input  1  pulse; begin full-array fill (accepted only in IDLE)
load_valid_i  input  1  load word valid
load_data_i  input  BIT_WIDTH_SRAM  load word
load_ready_o  output  1  high only in LOAD
load_done_o  output  1  one-cycle pulse after last word is written
rd_valid_i  input  1  read request
rd_ready_o  output  1  high only in IDLE
rd_address_i  input  BIT_WIDTH_ADDRESS  address broadcast to all sets
rd_set_mask_i  input  SET_NUM  per-set read enable
rd_data_o  output  BIT_WIDTH_SRAM*SET_NUM  set k at [k*BIT_WIDTH_SRAM +: BIT_WIDTH_SRAM]
rd_data_valid_o  output  1  rd_data_o valid
busy_o  output  1  high in LOAD

Behaviour:
- Clock and reset: one clock, clk. reset_n is asynchronous and active-low.
- Reset values:
  - State = IDLE.
  - load_addr and load_set counters = 0.
  - load_done_o = 0, rd_data_valid_o = 0, busy_o = 0, load_ready_o = 0.
  - rd_ready_o = 1 after reset release.
  - Registered read mask = 0, so rd_data_o = 0.
- FSM: IDLE, LOAD.
  - IDLE -> LOAD on load_start_i. Counters are cleared on entry.
  - LOAD -> IDLE on the edge that writes word (set SET_NUM-1, addr DEPTH_SRAM-1). load_done_o pulses in the following cycle, while in IDLE.
  - load_start_i during LOAD is ignored.
- Load:
  - A beat is accepted when load_valid_i & load_ready_o.
  - The write goes to macro load_set at load_addr, with CEB=0 and WEB=0 for that macro only.
  - After each beat, load_addr increments. When load_addr == DEPTH_SRAM-1 it wraps to 0 and load_set increments.
  - Total beats = SET_NUM*DEPTH_SRAM. Gaps in load_valid_i stall the engine without penalty.
- Read:
  - A request is accepted when rd_valid_i & rd_ready_o.
  - Each macro k with rd_set_mask_i[k]=1 gets CEB=0, WEB=1, A=rd_address_i.
  - Unmasked macros have CEB=1, with address and data gated to 0.
  - Throughput: 1 read per cycle, back-to-back.
  - Latency 1: rd_data_valid_o=1 in cycle t+1 for an acceptance in cycle t.
  - rd_data_o shows macro Q for sets in the mask registered at t. Unmasked sets read 0.
  - When rd_data_valid_o=0, rd_data_o = 0.
  - rd_address_i >= DEPTH_SRAM: the request is accepted and returns all-zero data with valid.
- Idle macros: all CEB=1, and address/write data are gated to 0 to save power.
- Simultaneous rd_valid_i and load_start_i in IDLE:
  - The read is accepted and its data returns normally at t+1.
  - LOAD begins at t+1.
- Mask all-zero read: still accepted; valid pulses with all-zero data.
- Reset mid-LOAD: returns to IDLE immediately, with no load_done_o. SRAM contents are partially written and undefined.

Optional Feature:
RD_OUT_REG_EN
- Defined:
  - rd_data_o and rd_data_valid_o gain an output register stage, giving read latency 2.
  - Throughput stays 1/cycle.
  - The register resets to 0.
  - load_done_o is delayed by one additional cycle so that it follows any in-flight read.
- Undefined: latency 1 as above.

Test Plan:
- SET_NUM=3, DEPTH_SRAM=4: reset -> rd_ready_o=1, rd_data_valid_o=0, rd_data_o=0.
- Fill sequence:
  - Stimulus: load_start_i, then 12 beats with data = 0x100+beat index.
  - Required: load_ready_o high for the whole LOAD, load_done_o pulses exactly once after beat 11.
  - Readback: reading addr 2 with mask 3'b111 returns set0=0x102, set1=0x106, set2=0x10A at t+1.
- Stalled load: toggle load_valid_i every other cycle -> identical memory image, and load_done_o is delayed accordingly.
- Masked read:
  - Stimulus: addr 1, mask 3'b010.
  - Required: only set1 slice = 0x105, other slices 0. CEB asserted low only on macro 1.
- Back-to-back reads of addr 0, 1, 3 -> valid high 3 consecutive cycles with correct data. Repeat with RD_OUT_REG_EN -> same data shifted one cycle.
- Reset mid-load:
  - Stimulus: assert reset_n low after 5 beats.
  - Required: state IDLE, no load_done_o.
  - Follow-up: a new full load then completes correctly.
